// File: rtl/key_pkg.sv
// Shared types and defaults for the key/button conditioning path.
package key_pkg;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_RISE_WAIT = 2'd1,
    ST_HIGH      = 2'd2,
    ST_FALL_WAIT = 2'd3
  } db_state_e;

  // 5 ms at 100 MHz
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs (buttons, switches).
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Synchronises a bouncing button and accepts a level change only after it has been
// stable for the full debounce window; emits a strobe on each accepted press.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press,
  output logic press_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
    $error("key_debounce: DEBOUNCE_CYCLES must be at least 2");
  end

  logic      sync2;
  db_state_e state;
  logic [CNT_W-1:0] cnt;

  sync_2ff #(
    .WIDTH(1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (btn_raw),
    .q  (sync2)
  );

  // press tracks {ST_HIGH, ST_FALL_WAIT}; it is updated alongside each state transition
  // so the output stays registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_LOW;
      cnt         <= '0;
      press       <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      unique case (state)
        ST_LOW: begin
          if (sync2) begin
            state <= ST_RISE_WAIT;
            cnt   <= '0;
          end
        end
        ST_RISE_WAIT: begin
          if (!sync2) begin
            state <= ST_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= ST_HIGH;
            cnt         <= '0;
            press       <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (!sync2) begin
            state <= ST_FALL_WAIT;
            cnt   <= '0;
          end
        end
        ST_FALL_WAIT: begin
          if (sync2) begin
            // Short release glitch: back to HIGH without a new strobe.
            state <= ST_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_LOW;
            cnt   <= '0;
            press <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= ST_LOW;
          cnt   <= '0;
          press <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed and randomised checks of key_debounce against a run-length reference model.
module tb_key_debounce;

  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_raw = 1'b0;
  logic press;
  logic press_pulse;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  // Reference model: two-stage delay line, then a counter of consecutive synchronised
  // samples that disagree with the accepted level. The first disagreeing sample starts
  // validation and D more must follow, so the level flips on the (D+1)th in a row.
  logic m_s1 = 1'b0;
  logic m_s2 = 1'b0;
  logic m_press = 1'b0;
  logic m_pulse = 1'b0;
  int   m_run = 0;

  key_debounce #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .press      (press),
    .press_pulse(press_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic b, input logic r);
    if (r) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_press = 1'b0; m_pulse = 1'b0; m_run = 0;
    end else begin
      m_pulse = 1'b0;
      if (m_s2 != m_press) m_run++;
      else m_run = 0;
      if (m_run == int'(D) + 1) begin
        m_pulse = m_s2 & ~m_press;
        m_press = m_s2;
        m_run   = 0;
      end
      m_s2 = m_s1;
      m_s1 = b;
    end
  endtask

  // One clock: drive on the falling edge, update the model at the rising edge, sample 1ns later.
  task automatic step(input logic b, input logic r);
    @(negedge clk);
    btn_raw = b;
    rst     = r;
    @(posedge clk);
    model_edge(b, r);
    #1;
    chk("press_model", press, m_press);
    chk("pulse_model", press_pulse, m_pulse);
    if (press_pulse === 1'b1) pulse_cnt++;
  endtask

  task automatic steps(input int n, input logic b);
    for (int i = 0; i < n; i++) step(b, 1'b0);
  endtask

  initial begin
    // Reset
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("reset_press", press, 1'b0);
    chk("reset_pulse", press_pulse, 1'b0);

    // Clean press: btn_raw first sampled at edge E
    step(1'b1, 1'b0);
    steps(5, 1'b1);
    chk("clean_before_window", press, 1'b0);
    step(1'b1, 1'b0);
    chk("clean_press_E6", press, 1'b1);
    chk("clean_pulse_E6", press_pulse, 1'b1);
    step(1'b1, 1'b0);
    chk("clean_pulse_E7", press_pulse, 1'b0);
    chk("clean_press_E7", press, 1'b1);
    steps(10, 1'b0);
    chk("clean_release", press, 1'b0);

    // Rising bounce: 1x3, 0x2, then held
    pulse_cnt = 0;
    steps(3, 1'b1);
    steps(2, 1'b0);
    chk_int("bounce_no_pulse", pulse_cnt, 0);
    step(1'b1, 1'b0);
    steps(5, 1'b1);
    chk("bounce_before_window", press, 1'b0);
    step(1'b1, 1'b0);
    chk("bounce_pulse_F6", press_pulse, 1'b1);
    steps(4, 1'b1);
    chk_int("bounce_one_pulse", pulse_cnt, 1);

    // Release glitch: 0x3 then back to 1 keeps press high, no new strobe
    pulse_cnt = 0;
    steps(3, 1'b0);
    steps(8, 1'b1);
    chk("glitch_press_held", press, 1'b1);
    step(1'b0, 1'b0);
    steps(5, 1'b0);
    chk("release_before_window", press, 1'b1);
    step(1'b0, 1'b0);
    chk("release_press_G6", press, 1'b0);
    chk_int("release_no_pulse", pulse_cnt, 0);
    steps(3, 1'b0);

    // Reset mid-validation with btn_raw held high
    steps(4, 1'b1);
    step(1'b1, 1'b1);
    chk("midreset_press", press, 1'b0);
    steps(6, 1'b1);
    chk("midreset_before_window", press, 1'b0);
    step(1'b1, 1'b0);
    chk("midreset_press_F6", press, 1'b1);
    chk("midreset_pulse_F6", press_pulse, 1'b1);

    // Reset while pressed: drops with no strobe
    steps(3, 1'b1);
    step(1'b1, 1'b1);
    chk("reset_while_high_press", press, 1'b0);
    chk("reset_while_high_pulse", press_pulse, 1'b0);
    steps(12, 1'b0);

    // Two held presses with a release between: two strobes
    pulse_cnt = 0;
    steps(20, 1'b1);
    steps(12, 1'b0);
    steps(20, 1'b1);
    steps(12, 1'b0);
    chk_int("two_presses", pulse_cnt, 2);

    // Window edges in raw cycles: D+1 high is the shortest accepted glitch
    pulse_cnt = 0;
    steps(D + 1, 1'b1);
    steps(12, 1'b0);
    chk_int("window_accept", pulse_cnt, 1);
    pulse_cnt = 0;
    steps(D, 1'b1);
    steps(12, 1'b0);
    steps(D - 1, 1'b1);
    steps(12, 1'b0);
    chk_int("window_reject", pulse_cnt, 0);

    // Randomised runs with occasional resets
    for (int k = 0; k < 150; k++) begin
      logic b;
      int   len;
      b   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 9));
      for (int i = 0; i < len; i++) step(b, ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
